// File: rtl/corevx_cache_traffic_gen_if.sv
// Core-side request/response port of corevx_cache, as driven by the traffic
// generator (master) and served by the cache or a memory model (slave).
interface corevx_cache_traffic_gen_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic [1:0]            c_cmd;
  logic [ADDR_WIDTH-1:0] c_address;
  logic [DATA_WIDTH-1:0] c_store_data;
  logic                  c_done;
  logic [1:0]            c_response;
  logic [DATA_WIDTH-1:0] c_load_data;

  modport master (
    output c_cmd,
    output c_address,
    output c_store_data,
    input  c_done,
    input  c_response,
    input  c_load_data
  );

  modport slave (
    input  c_cmd,
    input  c_address,
    input  c_store_data,
    output c_done,
    output c_response,
    output c_load_data
  );

endinterface

// File: rtl/corevx_cache_traffic_gen.sv
// corevx_cache_traffic_gen: writes a seeded LFSR pattern over a strided address
// range, replays the seed and reads the range back, counting data mismatches
// and error responses.
// Optional feature: define CACHE_TRAFFIC_GEN_INTERLEAVE_EN to compile in the
// read-after-write (interleave) mode selected by the `interleave` input.
module corevx_cache_traffic_gen #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           COUNT        = 1000,
  parameter int unsigned           STRIDE_SHIFT = 5,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter logic [31:0]           SEED         = 32'h13EA9C84
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       interleave,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [15:0]                error_count,
  output logic [ADDR_WIDTH-1:0]      first_error_addr,
  corevx_cache_traffic_gen_if.master c_if
);

  localparam logic [31:0] LFSR_MASK = 32'h80200003;
  localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [15:0] LAST_IDX  = 16'(COUNT);

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_DONE
`ifdef CACHE_TRAFFIC_GEN_INTERLEAVE_EN
    , S_IL_WR,
    S_IL_RD
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           lfsr_q, lfsr_d;
  logic [15:0]           idx_q, idx_d;
  logic [1:0]            cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [15:0]           err_q, err_d;
  logic [ADDR_WIDTH-1:0] fea_q, fea_d;

  logic                  req_done;
  logic                  last;
  logic [31:0]           lfsr_adv;
  logic [31:0]           lfsr_seed_adv;
  logic                  il_sel;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] addr_of(input logic [15:0] i);
    return BASE_ADDR + (ADDR_WIDTH'(i) << STRIDE_SHIFT);
  endfunction

`ifdef CACHE_TRAFFIC_GEN_INTERLEAVE_EN
  assign il_sel = interleave;
`else
  logic unused_interleave;
  assign unused_interleave = interleave;
  assign il_sel            = 1'b0;
`endif

  // Next-state, request sequencing and error accounting.
  // The reseed between the write and read passes is folded into the last
  // write's completion (load SEED and advance in one step), so no cycle is lost.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    exp_d   = exp_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fea_d   = fea_q;

    req_done      = c_if.c_done && (cmd_q != CMD_NONE);
    last          = (idx_q == LAST_IDX);
    lfsr_adv      = lfsr_step(lfsr_q);
    lfsr_seed_adv = lfsr_step(SEED_EFF);

    if (req_done && ((c_if.c_response != 2'd0) ||
                     ((cmd_q == CMD_READ) && (c_if.c_load_data != exp_q)))) begin
      if (err_q != '1) begin
        err_d = err_q + 16'd1;
      end
      if (err_q == '0) begin
        fea_d = addr_q;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d   = '0;
          fea_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          idx_d   = 16'd1;
          lfsr_d  = lfsr_seed_adv;
          cmd_d   = CMD_WRITE;
          addr_d  = addr_of(16'd1);
          wdata_d = lfsr_seed_adv[DATA_WIDTH-1:0];
          exp_d   = lfsr_seed_adv[DATA_WIDTH-1:0];
`ifdef CACHE_TRAFFIC_GEN_INTERLEAVE_EN
          state_d = il_sel ? S_IL_WR : S_WR;
`else
          state_d = S_WR;
`endif
        end
      end

      S_WR: begin
        if (req_done) begin
          if (last) begin
            state_d = S_RD;
            idx_d   = 16'd1;
            lfsr_d  = lfsr_seed_adv;
            cmd_d   = CMD_READ;
            addr_d  = addr_of(16'd1);
            wdata_d = '0;
            exp_d   = lfsr_seed_adv[DATA_WIDTH-1:0];
          end else begin
            idx_d   = idx_q + 16'd1;
            lfsr_d  = lfsr_adv;
            addr_d  = addr_of(idx_q + 16'd1);
            wdata_d = lfsr_adv[DATA_WIDTH-1:0];
            exp_d   = lfsr_adv[DATA_WIDTH-1:0];
          end
        end
      end

      S_RD: begin
        if (req_done) begin
          if (last) begin
            state_d = S_DONE;
            cmd_d   = CMD_NONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            idx_d   = idx_q + 16'd1;
            lfsr_d  = lfsr_adv;
            addr_d  = addr_of(idx_q + 16'd1);
            exp_d   = lfsr_adv[DATA_WIDTH-1:0];
          end
        end
      end

`ifdef CACHE_TRAFFIC_GEN_INTERLEAVE_EN
      // Read back the index just written; exp_q still holds its pattern word.
      S_IL_WR: begin
        if (req_done) begin
          state_d = S_IL_RD;
          cmd_d   = CMD_READ;
          wdata_d = '0;
        end
      end

      S_IL_RD: begin
        if (req_done) begin
          if (last) begin
            state_d = S_DONE;
            cmd_d   = CMD_NONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            state_d = S_IL_WR;
            idx_d   = idx_q + 16'd1;
            lfsr_d  = lfsr_adv;
            cmd_d   = CMD_WRITE;
            addr_d  = addr_of(idx_q + 16'd1);
            wdata_d = lfsr_adv[DATA_WIDTH-1:0];
            exp_d   = lfsr_adv[DATA_WIDTH-1:0];
          end
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        cmd_d   = CMD_NONE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      idx_q   <= '0;
      cmd_q   <= CMD_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fea_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fea_q   <= fea_d;
    end
  end

  assign c_if.c_cmd        = cmd_q;
  assign c_if.c_address    = addr_q;
  assign c_if.c_store_data = wdata_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign pass              = pass_q;
  assign error_count       = err_q;
  assign first_error_addr  = fea_q;

endmodule

// File: tb/tb_corevx_cache_traffic_gen.sv
// Scoreboard bench for corevx_cache_traffic_gen: a memory responder serves the
// core port, expected requests and end-of-run status are queued by stimulus
// and popped by monitors.
module tb_corevx_cache_traffic_gen;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int CNT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          interleave = 1'b0;
  logic          busy, done, pass;
  logic [15:0]   error_count;
  logic [AW-1:0] first_error_addr;

  corevx_cache_traffic_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  corevx_cache_traffic_gen #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .COUNT       (CNT),
    .STRIDE_SHIFT(5),
    .BASE_ADDR   (32'h0),
    .SEED        (32'h13EA9C84)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .interleave      (interleave),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .error_count     (error_count),
    .first_error_addr(first_error_addr),
    .c_if            (bus.master)
  );

  always #5 clk = ~clk;

  // Hand-computed LFSR words (seed 0x13EA9C84, mask 0x80200003, shift right).
  logic [31:0] PAT [4] = '{32'h09F54E42, 32'h04FAA721, 32'h825D5393, 32'hC10EA9CA};
  logic [31:0] ADR [4] = '{32'h20, 32'h40, 32'h60, 32'h80};

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic        pass;
    logic [15:0] ec;
    logic [31:0] fea;
    int          cycles;
  } st_t;

  req_t exp_q[$];
  st_t  st_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  // responder configuration
  int   lat = 1;
  int   err_write_n = 0;
  int   wr_seen = 0;
  logic flip_en = 1'b0;
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push_req(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.cmd = c; r.addr = a; r.data = d;
    exp_q.push_back(r);
  endfunction

  function automatic void push_st(input logic p, input logic [15:0] e, input logic [31:0] f, input int c);
    st_t s;
    s.pass = p; s.ec = e; s.fea = f; s.cycles = c;
    st_q.push_back(s);
  endfunction

  function automatic void push_normal();
    for (int i = 0; i < CNT; i++) push_req(2'd2, ADR[i], PAT[i]);
    for (int i = 0; i < CNT; i++) push_req(2'd1, ADR[i], 32'h0);
  endfunction

  function automatic void push_il();
    for (int i = 0; i < CNT; i++) begin
      push_req(2'd2, ADR[i], PAT[i]);
      push_req(2'd1, ADR[i], 32'h0);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Memory responder and request monitor.
  int          cnt = 0;
  logic [65:0] snap;
  always @(negedge clk) begin
    req_t r;
    if (!rst_n) begin
      bus.c_done      = 1'b0;
      bus.c_response  = 2'd0;
      bus.c_load_data = '0;
      cnt = 0;
    end else begin
      if (bus.c_done) begin
        bus.c_done     = 1'b0;
        bus.c_response = 2'd0;
        cnt = 0;
      end
      if (bus.c_cmd != 2'd0) begin
        if (cnt == 0) snap = {bus.c_cmd, bus.c_address, bus.c_store_data};
        else check("hold", {bus.c_cmd, bus.c_address, bus.c_store_data}, snap);
        if (cnt == lat) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_extra: got cmd %0h addr %0h expected no request", bus.c_cmd, bus.c_address);
          end else begin
            r = exp_q.pop_front();
            check("req_cmd", bus.c_cmd, r.cmd);
            check("req_addr", bus.c_address, r.addr);
            if (r.cmd == 2'd2) check("req_wdata", bus.c_store_data, r.data);
          end
          if (bus.c_cmd == 2'd2) begin
            wr_seen++;
            mem[bus.c_address] = bus.c_store_data;
            bus.c_response = (wr_seen == err_write_n) ? 2'd2 : 2'd0;
          end else begin
            bus.c_load_data = mem.exists(bus.c_address) ? mem[bus.c_address] : 32'h0;
            if (flip_en && bus.c_address == 32'h40) bus.c_load_data = bus.c_load_data ^ 32'h1;
            bus.c_response = 2'd0;
          end
          bus.c_done = 1'b1;
        end else begin
          cnt++;
        end
      end
    end
  end

  // End-of-run status monitor.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    st_t s;
    if (done && !done_prev) begin
      if (st_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL status_extra: got done=1 expected no completion");
      end else begin
        s = st_q.pop_front();
        check("pass", pass, s.pass);
        check("error_count", error_count, s.ec);
        check("first_error_addr", first_error_addr, s.fea);
        check("run_cycles", cyc - start_cyc, s.cycles);
        check("idle_at_done", {busy, bus.c_cmd}, 3'b000);
        check("pending_reqs", exp_q.size(), 0);
      end
    end
    done_prev = done;
  end

  task automatic do_start(input logic il);
    @(negedge clk);
    interleave = il;
    start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    interleave = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    if (!done) begin
      checks++; errors++;
      $display("FAIL run_timeout: got done=0 expected done within %0d cycles", budget);
    end
    @(negedge clk);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_bus", {bus.c_cmd, bus.c_address, bus.c_store_data}, 66'h0);
    check("rst_flags", {busy, done, pass}, 3'b000);
    check("rst_errs", {error_count, first_error_addr}, 48'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // clean normal run
    push_normal();
    push_st(1'b1, 16'd0, 32'h0, 16);
    do_start(1'b0);
    wait_done(200);

    // corrupted word at 0x40 on read-back
    flip_en = 1'b1;
    push_normal();
    push_st(1'b0, 16'd1, 32'h40, 16);
    do_start(1'b0);
    wait_done(200);
    flip_en = 1'b0;

    // error response on the third write
    wr_seen = 0;
    err_write_n = 3;
    push_normal();
    push_st(1'b0, 16'd1, 32'h60, 16);
    do_start(1'b0);
    wait_done(200);
    err_write_n = 0;

    // start during RD ignored, then reset mid-run
    flip_en = 1'b1;
    push_normal();
    do_start(1'b0);
    begin
      int n = 0;
      while (bus.c_cmd != 2'd1 && n < 100) begin @(negedge clk); n++; end
      check("reach_rd", bus.c_cmd, 2'd1);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int n = 0;
      while (error_count != 16'd1 && n < 100) begin @(negedge clk); n++; end
      check("midrun_err", error_count, 16'd1);
    end
    check("midrun_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_cmd", bus.c_cmd, 2'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_errs", error_count, 16'd0);
    exp_q.delete();
    flip_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_normal();
    push_st(1'b1, 16'd0, 32'h0, 16);
    do_start(1'b0);
    wait_done(200);

    // interleave request
`ifdef CACHE_TRAFFIC_GEN_INTERLEAVE_EN
    push_il();
`else
    push_normal();
`endif
    push_st(1'b1, 16'd0, 32'h0, 16);
    do_start(1'b1);
    wait_done(200);

    // slow responder: five wait cycles per request
    lat = 5;
    push_normal();
    push_st(1'b1, 16'd0, 32'h0, 48);
    do_start(1'b0);
    wait_done(400);
    lat = 1;

    check("status_left", st_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
